pipe_stage_chain: RTL and testbench

Parametrised chain of pipeline stage registers with per-stage valid bits, valid/ready handshakes at both ends, per-stage stall (hold plus bubble insertion) and per-stage flush. It generalises the fixed IF_ID/ID_EX/EX_MEM/MEM_WB registers of the five-stage core into one reusable block. It is used for the decoupled multi-cycle execution lanes of the next core revision. The hazard unit drives `stall`, the branch resolution logic drives `flush`, and the forwarding unit reads the `stage_valid`/`stage_data` taps.

---
 rtl/pipe_stage_chain_if.sv | 30 +++
 rtl/pipe_stage_chain.sv | 88 ++++++++
 tb/tb_pipe_stage_chain.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Handshake, control and tap bundle for pipe_stage_chain.
// The master side is the surrounding pipeline; the slave side is the chain itself.
interface pipe_stage_chain_if #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [STAGES-1:0]        stall;
  logic [STAGES-1:0]        flush;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*WIDTH-1:0]  stage_data;
  logic [OCC_W-1:0]         occupancy;

  modport master (
    output in_valid, in_data, out_ready, stall, flush,
    input  in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, stall, flush,
    output in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with valid/ready ends, per-stage
// stall (hold plus bubble) and per-stage flush; no skid buffering.
module pipe_stage_chain #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_stage_chain_if.slave bus
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [OCC_W-1:0]  r_occupancy;

  // w_load[STAGES] stands for the downstream consumer being ready
  logic [STAGES:0]   w_load;
  logic [STAGES-1:0] w_move;
  logic [STAGES-1:0] w_up;
  logic [STAGES-1:0] w_next_valid;
  logic [STAGES-1:0] w_data_en;
  logic [WIDTH-1:0]  w_src [STAGES];
  logic [OCC_W-1:0]  w_next_occ;

  // A stalled stage releases nothing, so its successor sees a bubble.
  always_comb begin
    w_load         = '0;
    w_move         = '0;
    w_load[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_move[k] = r_valid[k] & ~bus.stall[k] & w_load[k+1];
      w_load[k] = ~bus.stall[k] & (~r_valid[k] | w_move[k]);
    end
  end

  always_comb begin
    w_up         = '0;
    w_up[0]      = bus.in_valid & w_load[0];
    w_src[0]     = bus.in_data;
    for (int k = 1; k < STAGES; k++) begin
      w_up[k]  = w_move[k-1];
      w_src[k] = r_data[k-1];
    end
    w_next_valid = r_valid;
    w_data_en    = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush[k]) begin
        w_next_valid[k] = 1'b0;
      end else if (w_load[k]) begin
        w_next_valid[k] = w_up[k];
        w_data_en[k]    = w_up[k];
      end
    end
    w_next_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_next_occ = w_next_occ + OCC_W'(w_next_valid[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= '0;
      r_occupancy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid     <= w_next_valid;
      r_occupancy <= w_next_occ;
      for (int k = 0; k < STAGES; k++) begin
        if (w_data_en[k]) begin
          r_data[k] <= w_src[k];
        end
      end
    end
  end

  assign bus.in_ready    = w_load[0];
  assign bus.out_valid   = r_valid[STAGES-1];
  assign bus.out_data    = r_data[STAGES-1];
  assign bus.stage_valid = r_valid;
  assign bus.occupancy   = r_occupancy;

  for (genvar g = 0; g < STAGES; g++) begin : g_tap
    assign bus.stage_data[g*WIDTH +: WIDTH] = r_data[g];
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus random
// traffic against a slot-level reference model of the chain.
module tb_pipe_stage_chain;
  logic clk;
  logic rst_n;

  pipe_stage_chain_if #(.WIDTH(8), .STAGES(4)) bus ();
  pipe_stage_chain_if #(.WIDTH(8), .STAGES(1)) bus1 ();

  pipe_stage_chain #(.WIDTH(8), .STAGES(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  pipe_stage_chain #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: one slot per stage
  logic [3:0] m_v;
  logic [7:0] m_d [4];
  logic       last_acc;
  logic [7:0] q_out [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic [3:0] st, input logic [3:0] fl);
    logic [4:0] room;
    logic [3:0] leave;
    logic [3:0] up;
    logic [7:0] src [4];
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.stall     = st;
    bus.flush     = fl;
    #1;
    room[4] = ordy;
    for (int k = 3; k >= 0; k--) begin
      leave[k] = m_v[k] && !st[k] && room[k+1];
      room[k]  = !st[k] && (!m_v[k] || leave[k]);
    end
    chk("in_ready", 32'(bus.in_ready), 32'(room[0]));
    if (bus.out_valid && ordy) q_out.push_back(bus.out_data);
    last_acc = iv && bus.in_ready;
    up[0]  = iv && room[0];
    src[0] = id;
    for (int k = 1; k < 4; k++) begin
      up[k]  = leave[k-1];
      src[k] = m_d[k-1];
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (fl[k]) m_v[k] = 1'b0;
      else if (room[k]) begin
        m_v[k] = up[k];
        if (up[k]) m_d[k] = src[k];
      end
    end
    #1;
    chk("stage_valid", 32'(bus.stage_valid), 32'(m_v));
    chk("stage_data", 32'(bus.stage_data), {m_d[3], m_d[2], m_d[1], m_d[0]});
    chk("out_valid", 32'(bus.out_valid), 32'(m_v[3]));
    chk("out_data", 32'(bus.out_data), 32'(m_d[3]));
    chk("occupancy", 32'(bus.occupancy), 32'($countones(m_v)));
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 4'b0, 4'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int nsteps;
    int zeros;
    logic [3:0] rst_stall;
    logic [3:0] rfl;

    rst_n = 1'b0;
    m_v   = '0;
    for (int k = 0; k < 4; k++) m_d[k] = '0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.stall = 0; bus.flush = 0;
    bus1.in_valid = 0; bus1.in_data = 0; bus1.out_ready = 0; bus1.stall = 0; bus1.flush = 0;
    #1;
    chk("rst_stage_valid", 32'(bus.stage_valid), 32'h0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming 0x01..0x08
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i + 1), 1'b1, 4'b0, 4'b0);
      chk("stream_in_ready", 32'(last_acc), 32'h1);
      if (i >= 3) begin
        chk("stream_out", 32'(bus.out_data), 32'(i - 2));
        chk("stream_occ", 32'(bus.occupancy), 32'h4);
      end
    end
    drain();

    // backpressure 0xA0..0xA5
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'hA0 + 8'(idx), 1'b0, 4'b0, 4'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'h4);
    chk("bp_full_occ", 32'(bus.occupancy), 32'h4);
    q_out.delete();
    nsteps = 0;
    while ((idx < 6 || bus.out_valid) && nsteps < 20) begin
      step(idx < 6, 8'hA0 + 8'(idx), 1'b1, 4'b0, 4'b0);
      if (last_acc) idx++;
      nsteps++;
    end
    chk("bp_steps", 32'(nsteps), 32'h6);
    chk("bp_count", 32'(q_out.size()), 32'h6);
    for (int i = 0; i < q_out.size(); i++) chk("bp_order", 32'(q_out[i]), 32'hA0 + 32'(i));

    // stall bubble on stage 1
    drain();
    q_out.delete();
    idx   = 0;
    zeros = 0;
    for (int c = 0; c < 18; c++) begin
      step(idx < 8, 8'h31 + 8'(idx), 1'b1, (c == 4 || c == 5) ? 4'b0010 : 4'b0000, 4'b0);
      if (last_acc) idx++;
      if (c >= 2 && c <= 9 && !bus.stage_valid[2]) zeros++;
    end
    chk("stall_bubbles", 32'(zeros), 32'h2);
    chk("stall_count", 32'(q_out.size()), 32'h8);
    for (int i = 0; i < q_out.size(); i++) chk("stall_order", 32'(q_out[i]), 32'h31 + 32'(i));

    // flush stages 0 and 1
    step(1'b1, 8'h0A, 1'b1, 4'b0, 4'b0);
    step(1'b1, 8'h0B, 1'b1, 4'b0, 4'b0);
    step(1'b1, 8'h0C, 1'b1, 4'b0, 4'b0);
    chk("flush_pre_sv", 32'(bus.stage_valid), 32'b0111);
    step(1'b1, 8'h0D, 1'b1, 4'b0, 4'b0011);
    chk("flush_accept", 32'(last_acc), 32'h1);
    chk("flush_sv", 32'(bus.stage_valid), 32'b1100);
    chk("flush_out0", 32'(bus.out_data), 32'h0A);
    step(1'b0, 8'h00, 1'b1, 4'b0, 4'b0);
    chk("flush_out1", 32'(bus.out_data), 32'h0B);
    step(1'b0, 8'h00, 1'b1, 4'b0, 4'b0);
    chk("flush_empty", 32'(bus.out_valid), 32'h0);
    drain();

    // async reset mid-cycle with three items in flight
    for (int i = 0; i < 3; i++) step(1'b1, 8'h61 + 8'(i), 1'b0, 4'b0, 4'b0);
    chk("pre_rst_occ", 32'(bus.occupancy), 32'h3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sv", 32'(bus.stage_valid), 32'h0);
    chk("arst_sd", 32'(bus.stage_data), 32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_data", 32'(bus.out_data), 32'h0);
    chk("arst_occ", 32'(bus.occupancy), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    m_v = '0;
    for (int k = 0; k < 4; k++) m_d[k] = '0;
    #1 rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b1, 4'b0, 4'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 4'b0, 4'b0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_data", 32'(bus.out_data), 32'h55);
    drain();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        rst_stall[k] = ($urandom_range(0, 9) == 0);
        rfl[k]       = ($urandom_range(0, 19) == 0);
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), rst_stall, rfl);
    end
    drain();

    // single-stage instance
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_data = 8'h11; bus1.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("s1_hold_valid", 32'(bus1.out_valid), 32'h1);
    chk("s1_hold_data", 32'(bus1.out_data), 32'h11);
    chk("s1_occ", 32'(bus1.occupancy), 32'h1);
    @(negedge clk);
    bus1.in_data = 8'h22;
    #1 chk("s1_full_block", 32'(bus1.in_ready), 32'h0);
    bus1.out_ready = 1'b1;
    #1 chk("s1_pushpop_ready", 32'(bus1.in_ready), 32'h1);
    @(posedge clk); #1;
    chk("s1_swap_data", 32'(bus1.out_data), 32'h22);
    chk("s1_swap_valid", 32'(bus1.out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.in_data = 8'h33 + 8'(i * 17);
      #1 chk("s1_stream_ready", 32'(bus1.in_ready), 32'h1);
      @(posedge clk); #1;
      chk("s1_stream_data", 32'(bus1.out_data), 32'h33 + 32'(i * 17));
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s1_empty", 32'(bus1.out_valid), 32'h0);
    chk("s1_empty_occ", 32'(bus1.occupancy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
